// File: rtl/ram_port_arbiter.sv
// Two-port arbiter for a single-port synchronous RAM: CPU MEM stage (port 0) and UART loader (port 1).
// Round-robin on ties; every access takes a fixed three cycles from grant to acknowledge.
module ram_port_arbiter #(
  parameter int RAM_ADDRESS_BITWIDTH = 16,
  parameter int DATA_BITWIDTH        = 32
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            p0_req,
  input  logic                            p0_wr_en,
  input  logic [RAM_ADDRESS_BITWIDTH-1:0] p0_address,
  input  logic [DATA_BITWIDTH-1:0]        p0_write_data,
  output logic                            p0_ack,
  output logic [DATA_BITWIDTH-1:0]        p0_read_data,
  input  logic                            p1_req,
  input  logic                            p1_wr_en,
  input  logic [RAM_ADDRESS_BITWIDTH-1:0] p1_address,
  input  logic [DATA_BITWIDTH-1:0]        p1_write_data,
  output logic                            p1_ack,
  output logic [DATA_BITWIDTH-1:0]        p1_read_data,
  output logic [RAM_ADDRESS_BITWIDTH-1:0] ram_address,
  output logic [DATA_BITWIDTH-1:0]        ram_write_data,
  output logic                            ram_wr_en,
  input  logic [DATA_BITWIDTH-1:0]        ram_data,
  output logic                            busy,
  output logic                            grant_id
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state;
  logic   last_grant;
  logic   access_wr;
  logic   p0_eff;
  logic   p1_eff;
  logic   winner;

  // A port whose ack is high this cycle has just been served; its still-high req must not re-trigger.
  always_comb begin
    p0_eff = p0_req & ~p0_ack;
    p1_eff = p1_req & ~p1_ack;
    winner = (p0_eff & p1_eff) ? ~last_grant : p1_eff;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      last_grant     <= 1'b1;
      grant_id       <= 1'b0;
      access_wr      <= 1'b0;
      busy           <= 1'b0;
      p0_ack         <= 1'b0;
      p1_ack         <= 1'b0;
      p0_read_data   <= '0;
      p1_read_data   <= '0;
      ram_address    <= '0;
      ram_write_data <= '0;
      ram_wr_en      <= 1'b0;
    end else begin
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (p0_eff | p1_eff) begin
            grant_id       <= winner;
            last_grant     <= winner;
            access_wr      <= winner ? p1_wr_en : p0_wr_en;
            ram_wr_en      <= winner ? p1_wr_en : p0_wr_en;
            ram_address    <= winner ? p1_address : p0_address;
            ram_write_data <= winner ? p1_write_data : p0_write_data;
            busy           <= 1'b1;
            state          <= ACCESS;
          end
        end
        ACCESS: begin
          ram_wr_en <= 1'b0;
          state     <= RESP;
        end
        RESP: begin
          if (!access_wr) begin
            if (grant_id) p1_read_data <= ram_data;
            else          p0_read_data <= ram_data;
          end
          if (grant_id) p1_ack <= 1'b1;
          else          p0_ack <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ram_wr_en <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus random two-port traffic,
// compared every cycle against a timestamp-based transaction model.
module tb_ram_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          p0_req, p0_wr_en, p1_req, p1_wr_en;
  logic [AW-1:0] p0_address, p1_address;
  logic [DW-1:0] p0_write_data, p1_write_data;
  logic          p0_ack, p1_ack;
  logic [DW-1:0] p0_read_data, p1_read_data;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_write_data, ram_data;
  logic          ram_wr_en, busy, grant_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .RAM_ADDRESS_BITWIDTH(AW),
    .DATA_BITWIDTH(DW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .p0_req(p0_req), .p0_wr_en(p0_wr_en), .p0_address(p0_address),
    .p0_write_data(p0_write_data), .p0_ack(p0_ack), .p0_read_data(p0_read_data),
    .p1_req(p1_req), .p1_wr_en(p1_wr_en), .p1_address(p1_address),
    .p1_write_data(p1_write_data), .p1_ack(p1_ack), .p1_read_data(p1_read_data),
    .ram_address(ram_address), .ram_write_data(ram_write_data), .ram_wr_en(ram_wr_en),
    .ram_data(ram_data), .busy(busy), .grant_id(grant_id)
  );

  // Synchronous-read RAM the arbiter drives.
  logic [DW-1:0] env_mem [256];
  always @(posedge clk) begin
    if (ram_wr_en) env_mem[ram_address[7:0]] <= ram_write_data;
    ram_data <= env_mem[ram_address[7:0]];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Transaction model: a grant at edge g occupies edges g..g+2; write/read of memory lands at g+1,
  // the ack is shown after g+2, and arbitration resumes at g+3 with the just-acked port excluded.
  logic [DW-1:0] mmem [256];
  longint        ec = 0, g = 0;
  bit            have = 0, gp = 0, gwr = 0, last = 1;
  logic [DW-1:0] gval = '0;
  logic          m_ack0 = 0, m_ack1 = 0, m_wr = 0, m_busy = 0, m_gid = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_rd0 = '0, m_rd1 = '0;

  always @(posedge clk or negedge reset_n) begin
    bit e0, e1, w;
    ec++;
    if (!reset_n) begin
      have = 0; last = 1; m_gid = 0; m_addr = '0; m_wdata = '0;
      m_rd0 = '0; m_rd1 = '0; m_ack0 = 0; m_ack1 = 0;
    end else begin
      m_ack0 = 0; m_ack1 = 0;
      if (have && ec == g + 1) begin
        if (gwr) mmem[m_addr[7:0]] = m_wdata;
        else     gval = mmem[m_addr[7:0]];
      end
      if (have && ec == g + 2) begin
        if (gp) begin m_ack1 = 1; if (!gwr) m_rd1 = gval; end
        else    begin m_ack0 = 1; if (!gwr) m_rd0 = gval; end
      end
      if (!have || ec >= g + 3) begin
        e0 = p0_req && !(have && ec == g + 3 && !gp);
        e1 = p1_req && !(have && ec == g + 3 && gp);
        if (e0 || e1) begin
          w       = (e0 && e1) ? !last : e1;
          have    = 1; g = ec; gp = w; last = w; m_gid = w;
          gwr     = w ? p1_wr_en : p0_wr_en;
          m_addr  = w ? p1_address : p0_address;
          m_wdata = w ? p1_write_data : p0_write_data;
        end
      end
    end
    m_busy = have && (ec - g) < 2;
    m_wr   = have && ec == g && gwr;
  end

  always @(negedge clk) begin
    chk("p0_ack", p0_ack, m_ack0);
    chk("p1_ack", p1_ack, m_ack1);
    chk("p0_read_data", p0_read_data, m_rd0);
    chk("p1_read_data", p1_read_data, m_rd1);
    chk("ram_address", ram_address, m_addr);
    chk("ram_write_data", ram_write_data, m_wdata);
    chk("ram_wr_en", ram_wr_en, m_wr);
    chk("busy", busy, m_busy);
    chk("grant_id", grant_id, m_gid);
  end

  task automatic wait_ack(input bit port, output int n, output int nbusy, output int nwr,
                          output logic [AW-1:0] wr_addr);
    logic got;
    n = 0; nbusy = 0; nwr = 0; wr_addr = '0; got = 0;
    while (!got && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (busy) nbusy++;
      if (ram_wr_en) begin nwr++; wr_addr = ram_address; end
      got = port ? p1_ack : p0_ack;
    end
    chk("ack_seen", got, 1);
  endtask

  // One isolated access: drive, wait for the ack, release and confirm the ack is a single pulse.
  task automatic access(input bit port, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int n, output int nbusy, output int nwr, output logic [AW-1:0] wa);
    if (port) begin p1_req = 1; p1_wr_en = wr; p1_address = a; p1_write_data = d; end
    else      begin p0_req = 1; p0_wr_en = wr; p0_address = a; p0_write_data = d; end
    wait_ack(port, n, nbusy, nwr, wa);
    p0_req = 0; p1_req = 0;
    @(posedge clk); #1;
    chk("ack_pulse", port ? p1_ack : p0_ack, 0);
  endtask

  task automatic rand_port(inout logic req, inout logic wr, inout logic [AW-1:0] a,
                           inout logic [DW-1:0] d, input logic ack, input bit allow_new);
    if (req) begin
      if (ack) begin
        if (!allow_new || $urandom_range(0, 1) == 0) req = 0;
        else begin wr = $urandom_range(0, 1); a = AW'($urandom_range(0, 15)); d = $urandom; end
      end
    end else if (allow_new && $urandom_range(0, 2) == 0) begin
      req = 1; wr = $urandom_range(0, 1); a = AW'($urandom_range(0, 15)); d = $urandom;
    end
  endtask

  initial begin
    int n, nb, nw, k, cyc;
    logic [AW-1:0] wa;
    logic r0, w0, r1, w1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;

    p0_req = 0; p0_wr_en = 0; p0_address = '0; p0_write_data = '0;
    p1_req = 0; p1_wr_en = 0; p1_address = '0; p1_write_data = '0;
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = $urandom;
      mmem[i]    = env_mem[i];
    end
    env_mem[16] = 32'hDEADBEEF; mmem[16] = 32'hDEADBEEF;
    env_mem[5]  = 32'h0BADF00D; mmem[5]  = 32'h0BADF00D;
    reset_n = 1;
    #1 reset_n = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_wr_en", ram_wr_en, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_p0_rd", p0_read_data, 0);
    chk("rst_p1_ack", p1_ack, 0);

    // Single read by port 0.
    access(0, 0, 16'h0010, '0, n, nb, nw, wa);
    chk("rd_latency", n, 3);
    chk("rd_busy_cycles", nb, 2);
    chk("rd_data", p0_read_data, 32'hDEADBEEF);
    chk("rd_p1_quiet", p1_ack, 0);

    // Write by port 1, then read it back.
    access(1, 1, 16'h0003, 32'h12345678, n, nb, nw, wa);
    chk("wr_latency", n, 3);
    chk("wr_pulse_count", nw, 1);
    chk("wr_pulse_addr", wa, 16'h0003);
    chk("wr_rd_unchanged", p1_read_data, 0);
    access(1, 0, 16'h0003, '0, n, nb, nw, wa);
    chk("wr_readback", p1_read_data, 32'h12345678);
    chk("wr_readback_lat", n, 3);

    // Both request while in reset: port 0 wins the first tie.
    reset_n = 0;
    p0_req = 1; p0_wr_en = 0; p0_address = 16'h0010;
    p1_req = 1; p1_wr_en = 0; p1_address = 16'h0003;
    @(posedge clk); #1;
    reset_n = 1;
    wait_ack(0, n, nb, nw, wa);
    chk("tie_p0_first", n, 3);
    chk("tie_p1_not_yet", p1_ack, 0);
    p0_req = 0;
    wait_ack(1, n, nb, nw, wa);
    chk("tie_p1_after", n, 3);
    chk("tie_p1_data", p1_read_data, 32'h12345678);

    // Continuous contention: grants must alternate starting with port 0.
    p0_req = 1; p1_req = 1;
    k = 0; cyc = 0;
    while (k < 8 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (p0_ack || p1_ack) begin
        chk("cont_order", p1_ack, k % 2);
        k++;
      end
    end
    chk("cont_count", k, 8);
    p0_req = 0; p1_req = 0;
    @(posedge clk); #1;

    // Ack masking: port 0 keeps req high through its ack cycle.
    p0_req = 1; p0_wr_en = 1; p0_address = 16'h0007; p0_write_data = 32'h5555AAAA;
    wait_ack(0, n, nb, nw, wa);
    chk("mask_first_lat", n, 3);
    chk("mask_first_wr", nw, 1);
    @(posedge clk); #1;
    chk("mask_no_ack", p0_ack, 0);
    chk("mask_idle", busy, 0);
    chk("mask_no_wr", ram_wr_en, 0);
    @(posedge clk); #1;
    chk("mask_regrant", busy, 1);
    chk("mask_regrant_wr", ram_wr_en, 1);
    wait_ack(0, n, nb, nw, wa);
    chk("mask_second_lat", n, 2);
    p0_req = 0;
    @(posedge clk); #1;

    // Reset during the ACCESS cycle of a write.
    p0_req = 1; p0_wr_en = 1; p0_address = 16'h0005; p0_write_data = 32'hA5A5A5A5;
    @(posedge clk); #1;
    chk("rstw_pulse", ram_wr_en, 1);
    #2 reset_n = 0;
    #1;
    chk("rstw_wr_drop", ram_wr_en, 0);
    chk("rstw_busy", busy, 0);
    chk("rstw_addr", ram_address, 0);
    p0_req = 0;
    @(posedge clk); #1;
    reset_n = 1;
    chk("rstw_ack", p0_ack, 0);
    chk("rstw_mem_kept", env_mem[5], 32'h0BADF00D);
    access(1, 0, 16'h0005, '0, n, nb, nw, wa);
    chk("rstw_after_lat", n, 3);
    chk("rstw_after_data", p1_read_data, 32'h0BADF00D);

    // Random two-port traffic; requesters hold req and fields until their ack.
    r0 = 0; w0 = 0; a0 = '0; d0 = '0; r1 = 0; w1 = 0; a1 = '0; d1 = '0;
    for (int c = 0; c < 900; c++) begin
      @(posedge clk); #1;
      rand_port(r0, w0, a0, d0, p0_ack, 1);
      rand_port(r1, w1, a1, d1, p1_ack, 1);
      p0_req = r0; p0_wr_en = w0; p0_address = a0; p0_write_data = d0;
      p1_req = r1; p1_wr_en = w1; p1_address = a1; p1_write_data = d1;
    end
    cyc = 0;
    while ((r0 || r1) && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      rand_port(r0, w0, a0, d0, p0_ack, 0);
      rand_port(r1, w1, a1, d1, p1_ack, 0);
      p0_req = r0; p1_req = r1;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Shares the single-port data RAM between two requesters: port 0 is the CPU MEM stage and port 1 is the UART program/data loader. A three-state FSM grants one access at a time and registers all RAM-side signals. It returns read data and a one-cycle acknowledge to the winning port. Fairness is round-robin, and latency is a fixed 3 cycles per access.

## Interface
- RAM_ADDRESS_BITWIDTH, default 16: RAM word-address width; all address ports use this width.
- DATA_BITWIDTH, default 32: data width.
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- p0_req / p1_req  input  1  access request; held high with fields stable until the matching ack.
- p0_wr_en / p1_wr_en  input  1  1 = write, 0 = read.
- p0_address / p1_address  input  RAM_ADDRESS_BITWIDTH  word address.
- p0_write_data / p1_write_data  input  DATA_BITWIDTH  write data.
- p0_ack / p1_ack  output  1  registered one-cycle completion pulse.
- p0_read_data / p1_read_data  output  DATA_BITWIDTH  registered read result; holds its value between reads.
- ram_address  output  RAM_ADDRESS_BITWIDTH  to RAM, registered.
- ram_write_data  output  DATA_BITWIDTH  to RAM, registered.
- ram_wr_en  output  1  to RAM, registered.
- ram_data  input  DATA_BITWIDTH  RAM read data; valid one cycle after the address is presented (synchronous read).
- busy  output  1  FSM is not in IDLE.
- grant_id  output  1  port owning the current or most recent access.

## Operation
- FSM has three states: IDLE, ACCESS, RESP.
- IDLE:
  - Forms the effective requests: p0_eff = p0_req & ~p0_ack and p1_eff = p1_req & ~p1_ack. The ack masking prevents the still-high req of the port being acknowledged from re-triggering.
  - If no effective request exists, stay in IDLE.
  - If exactly one port has an effective request, grant it.
  - If both do, grant the port that was not granted last. The last_grant register resets to 1, so port 0 wins the first tie.
  - On grant: latch the winner's address, write data and wr_en into ram_address, ram_write_data and ram_wr_en; set grant_id and last_grant; go to ACCESS.
- ACCESS:
  - The RAM sees the address and, for a write, the write enable.
  - At the clock edge, clear ram_wr_en so the write pulse is exactly one cycle; go to RESP.
- RESP:
  - ram_data is valid.
  - At the clock edge, for a read, load the granted port's read_data from ram_data. For a write, leave read_data unchanged.
  - Set the granted port's ack to 1; go to IDLE.
- ack pulses: p0_ack and p1_ack are high for exactly one cycle (the first IDLE cycle after RESP) and are cleared at the next edge. They are never high together.
- Non-granted ports: requests of the port not currently granted are ignored until the FSM returns to IDLE. That port's req must stay high; no request is lost.
- Ignored inputs: changes to a port's fields while it is granted are ignored, because the fields were latched at grant.
- Reset values: FSM=IDLE, last_grant=1, grant_id=0, all acks 0, ram_wr_en 0, ram_address 0, ram_write_data 0, both read_data 0, busy 0.

## Timing
- Latency: grant at edge E0 (IDLE→ACCESS), E1 (ACCESS→RESP), E2 (RESP→IDLE with ack and read_data loaded). ack is visible in the cycle after E2, and read_data is valid in the same cycle as ack.
- Throughput: one access per 3 cycles. The other port can be granted in the ack cycle, so arbitration in that cycle still happens.
- Back-to-back requests from the same port: the next access is granted at the earliest one cycle after ack drops, provided req is still high then. An acked port's req in its ack cycle is treated as already served.
- Write-enable pulse: ram_wr_en is high for exactly the ACCESS cycle of a write and low in all other cycles.
- busy is high in ACCESS and RESP.
- Reset mid-operation: asserting reset_n low forces all outputs to their reset values immediately, including ram_wr_en=0. Any in-flight access is dropped with no ack; the requester must re-request after reset.
- Requests asserted while reset_n is low are evaluated on the first edge after release.

## Test plan
- Single read: preload RAM[0x0010]=0xDEADBEEF; p0_req=1, p0_wr_en=0, p0_address=0x0010 at E0 → p0_ack high exactly one cycle after E2 with p0_read_data=0xDEADBEEF; p1_ack stays 0; busy high for 2 cycles.
- Single write then read: p1 writes 0x12345678 to 0x0003 → ram_wr_en high exactly one cycle, ram_address=0x0003; p1_read_data is unchanged on the write ack. A following p1 read of 0x0003 returns 0x12345678.
- Simultaneous requests from reset: p0 and p1 both request at E0 → p0 is served first (ack at E2). p1 is granted in p0's ack cycle, and its ack comes 3 cycles after p0's ack.
- Continuous contention: both reqs held high for 12 cycles, re-requesting after each ack → grants alternate 0,1,0,1; no port is acked twice in a row; acks never overlap.
- Ack masking: p0 holds req high through its ack cycle while p1 is idle → exactly one access is performed, with no duplicate write and no ack in the following cycle. p0 is re-granted only after its ack has dropped.
- Reset mid-write: assert reset_n=0 in the ACCESS cycle of a p0 write → ram_wr_en drops to 0 immediately, no ack is issued, busy=0. After release, a new p1 request completes normally in 3 cycles.
